hazard_unit_ml: RTL
===================

Name: hazard_unit_ml

Overview:
- Parametrised load-use hazard detection and pipeline-control unit for the 5-stage MIPS core.
- Sits in ID. Compares the IF/ID source registers against the ID/EX load destination.
- Inserts a configurable number of bubbles (LOAD_LAT) for multi-cycle data memory, freezes the whole pipe while data memory is busy, and arbitrates branch flush against stall.
- New relative to the previous single-bubble unit: $zero exclusion, per-operand use qualifiers, multi-bubble FSM, memory freeze, and flush arbitration.

Parameters:
- REG_AW, 5, register address width.
- LOAD_LAT, 1, bubbles inserted per load-use hazard. Legal range 1..15; 1 gives the classic single bubble.
- CNT_W, 4, stall down-counter width. Must satisfy 2^CNT_W > LOAD_LAT.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- id_rs_i  in  REG_AW  IF/ID RegisterRs (inst[25:21]).
- id_rt_i  in  REG_AW  IF/ID RegisterRt (inst[20:16]).
- id_use_rs_i  in  1  ID instruction reads rs.
- id_use_rt_i  in  1  ID instruction reads rt.
- ex_memread_i  in  1  ID/EX.MemRead.
- ex_rt_i  in  REG_AW  ID/EX load destination register.
- branch_taken_i  in  1  branch resolved taken in ID this cycle.
- dmem_busy_i  in  1  data memory not ready; whole pipe must hold.
- pc_stall_o  out  1  hold PC.
- ifid_stall_o  out  1  hold IF/ID.
- bubble_o  out  1  zero ID/EX control field (MUX8 select).
- ifid_flush_o  out  1  squash IF/ID.
- freeze_o  out  1  hold ID/EX, EX/MEM, MEM/WB.
- stall_state_o  out  1  1 while in STALL state.

Behaviour:
- Reset (rst_i=0, async): state=RUN, cnt=0. All outputs 0 while rst_i=0, regardless of inputs.
- hit = ex_memread_i & (ex_rt_i!=0) & ((id_use_rs_i & ex_rt_i==id_rs_i) | (id_use_rt_i & ex_rt_i==id_rt_i)).
- Register 0 never causes a stall.
- All outputs are combinational from state and current inputs (Mealy), so a stall takes effect in the detection cycle.
- Priority order: freeze > stall > flush.

States:
- RUN:
  - dmem_busy_i=1: freeze_o=pc_stall_o=ifid_stall_o=1, bubble_o=0, ifid_flush_o=0, no state change. A hit is ignored this cycle and re-evaluated when busy drops, since the pipe is held.
  - Else if hit: pc_stall_o=ifid_stall_o=bubble_o=1, ifid_flush_o=0. If LOAD_LAT==1, stay in RUN. Else cnt<=LOAD_LAT-1 and go to STALL.
  - Else: ifid_flush_o=branch_taken_i, all other outputs 0.
- STALL:
  - dmem_busy_i=1: freeze behaviour as in RUN; cnt and state hold.
  - Else: pc_stall_o=ifid_stall_o=bubble_o=1, ifid_flush_o=0 (branch_taken_i ignored), stall_state_o=1, cnt<=cnt-1. When cnt==1, next state is RUN.
  - hit is not re-evaluated in STALL; a bubble already occupies EX.

Bubble and stall counts:
- Total bubbles per hazard = LOAD_LAT cycles with pc_stall_o=1, excluding frozen cycles.
- Back-to-back hazards: after returning to RUN, a new hit in the first RUN cycle stalls again immediately. No dead cycle.
- cnt never underflows. Entering STALL requires LOAD_LAT≥2, so cnt≥1 on entry.

Reset mid-STALL: returns to RUN with cnt=0 asynchronously; outputs drop to 0 immediately.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: adds outputs perf_bubble_o[31:0] and perf_flush_o[31:0], plus input perf_clr_i (synchronous clear, highest priority after reset).
  - perf_bubble_o increments on every cycle with bubble_o=1 and freeze_o=0.
  - perf_flush_o increments on every cycle with ifid_flush_o=1.
  - Both wrap at 2^32. Both reset to 0.
- Not defined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- LOAD_LAT=1: ex_memread=1, ex_rt=5, id_rs=5, id_use_rs=1 -> exactly 1 cycle of pc_stall/ifid_stall/bubble=1. Drop ex_memread next cycle -> all 0.
- LOAD_LAT=3, same hazard -> 3 consecutive stall cycles; stall_state_o=1 on cycles 2–3; RUN on cycle 4.
- ex_rt=0, id_rs=0, id_use_rs=1, ex_memread=1 -> no stall. ex_rt=7, id_rt=7, id_use_rt=0 -> no stall.
- LOAD_LAT=3, dmem_busy_i=1 for 2 cycles during the 2nd bubble -> freeze_o=1 for 2 cycles, bubble_o=0 while frozen, then the remaining bubbles complete. Total bubble cycles = 3.
- hit and branch_taken_i in the same cycle -> ifid_flush_o=0 while stalling. Next RUN cycle with hit=0 and branch_taken_i=1 -> ifid_flush_o=1 for 1 cycle.
- rst_i pulsed low during STALL (LOAD_LAT=4, cnt=2) -> outputs 0 immediately; after release, state RUN and no residual bubbles. With HAZARD_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/hazard_unit_ml_if.sv
// Pipeline-control bundle between the ID-stage hazard unit and the core.
// The performance counter signals exist only when HAZARD_PERF_CNT_EN is defined.
interface hazard_unit_ml_if #(
  parameter int REG_AW = 5
);
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_use_rs_i;
  logic              id_use_rt_i;
  logic              ex_memread_i;
  logic [REG_AW-1:0] ex_rt_i;
  logic              branch_taken_i;
  logic              dmem_busy_i;
  logic              pc_stall_o;
  logic              ifid_stall_o;
  logic              bubble_o;
  logic              ifid_flush_o;
  logic              freeze_o;
  logic              stall_state_o;
`ifdef HAZARD_PERF_CNT_EN
  logic              perf_clr_i;
  logic [31:0]       perf_bubble_o;
  logic [31:0]       perf_flush_o;
`endif

  // Core side: drives the pipeline observations, receives the controls.
  modport master (
`ifdef HAZARD_PERF_CNT_EN
    output perf_clr_i,
    input  perf_bubble_o, perf_flush_o,
`endif
    output id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
    output ex_memread_i, ex_rt_i, branch_taken_i, dmem_busy_i,
    input  pc_stall_o, ifid_stall_o, bubble_o, ifid_flush_o,
    input  freeze_o, stall_state_o
  );

  // Hazard unit side.
  modport slave (
`ifdef HAZARD_PERF_CNT_EN
    input  perf_clr_i,
    output perf_bubble_o, perf_flush_o,
`endif
    input  id_rs_i, id_rt_i, id_use_rs_i, id_use_rt_i,
    input  ex_memread_i, ex_rt_i, branch_taken_i, dmem_busy_i,
    output pc_stall_o, ifid_stall_o, bubble_o, ifid_flush_o,
    output freeze_o, stall_state_o
  );
endinterface

// File: rtl/hazard_unit_ml.sv
// Load-use hazard detection and pipeline control for the 5-stage MIPS core.
// Inserts LOAD_LAT bubbles per load-use hazard, freezes the whole pipe while
// data memory is busy, and lets freeze > stall > branch flush.
// Optional macro HAZARD_PERF_CNT_EN adds bubble/flush performance counters.
module hazard_unit_ml #(
  parameter int REG_AW   = 5,
  parameter int LOAD_LAT = 1,   // 1..15 bubbles per hazard
  parameter int CNT_W    = 4    // 2**CNT_W must exceed LOAD_LAT
) (
  input  logic             clk_i,
  input  logic             rst_i,   // asynchronous, active-low
  hazard_unit_ml_if.slave  hz
);

  localparam logic [0:0]       ST_RUN   = 1'b0;
  localparam logic [0:0]       ST_STALL = 1'b1;
  // The detection cycle is the first bubble, so STALL covers the rest.
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [0:0]       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hit;
  logic             pc_stall, ifid_stall, bubble, ifid_flush, freeze, stall_state;

  // Hazard compare; register 0 is never a real dependency.
  always_comb begin
    hit = hz.ex_memread_i && (hz.ex_rt_i != '0) &&
          ((hz.id_use_rs_i && (hz.ex_rt_i == hz.id_rs_i)) ||
           (hz.id_use_rt_i && (hz.ex_rt_i == hz.id_rt_i)));
  end

  // Mealy control: busy freezes everything, STALL burns down the counter,
  // a fresh hit stalls in its own detection cycle, otherwise flush passes.
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    bubble      = 1'b0;
    ifid_flush  = 1'b0;
    freeze      = 1'b0;
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    stall_state = (state_reg == ST_STALL);
    if (hz.dmem_busy_i) begin
      freeze     = 1'b1;
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
    end else if (state_reg == ST_STALL) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      bubble     = 1'b1;
      cnt_next   = cnt_reg - CNT_ONE;
      if (cnt_reg == CNT_ONE) begin
        state_next = ST_RUN;
      end
    end else if (hit) begin
      pc_stall   = 1'b1;
      ifid_stall = 1'b1;
      bubble     = 1'b1;
      if (LOAD_LAT > 1) begin
        cnt_next   = CNT_INIT;
        state_next = ST_STALL;
      end
    end else begin
      ifid_flush = hz.branch_taken_i;
    end
  end

  // Outputs are forced low for as long as reset is held.
  assign hz.pc_stall_o    = pc_stall    & rst_i;
  assign hz.ifid_stall_o  = ifid_stall  & rst_i;
  assign hz.bubble_o      = bubble      & rst_i;
  assign hz.ifid_flush_o  = ifid_flush  & rst_i;
  assign hz.freeze_o      = freeze      & rst_i;
  assign hz.stall_state_o = stall_state & rst_i;

  // State and bubble counter registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_bubble_reg;
  logic [31:0] perf_flush_reg;

  // Event counters: bubbles exclude frozen cycles; both wrap naturally.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      perf_bubble_reg <= '0;
      perf_flush_reg  <= '0;
    end else if (hz.perf_clr_i) begin
      perf_bubble_reg <= '0;
      perf_flush_reg  <= '0;
    end else begin
      if (bubble && !freeze) begin
        perf_bubble_reg <= perf_bubble_reg + 32'd1;
      end
      if (ifid_flush) begin
        perf_flush_reg <= perf_flush_reg + 32'd1;
      end
    end
  end

  assign hz.perf_bubble_o = perf_bubble_reg;
  assign hz.perf_flush_o  = perf_flush_reg;
`endif

endmodule
